skip_seq_ctrl: RTL
==================

Name: skip_seq_ctrl

Overview:
- Programmable controller and sequencer for the team's skip-by-N counting datapath.
- Takes a configuration of terminal value, skip period and run mode through a valid/ready port, then is armed and started.
- Emits the skip sequence as a backpressured valid/ready stream with a last flag.
- Sits between the control/CSR logic and any consumer of skip-count values. Replaces free-running skip counters with a start/stop/reconfigurable engine.

Parameters:
- WIDTH, 9, width of count values and cfg_limit.
- PER_W, 4, width of cfg_period.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_limit  in  WIDTH  terminal value (inclusive).
- cfg_period  in  PER_W  skip period P.
- cfg_mode  in  1  0 = one-shot, 1 = continuous wrap.
- start  in  1  level/pulse; sampled only in ARMED.
- stop  in  1  abort; sampled only in RUN.
- cnt_valid  out  1  count beat valid.
- cnt_ready  in  1  consumer ready.
- cnt_data  out  WIDTH  current count value.
- cnt_last  out  1  beat is last of a pass.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt_data=0, phase=0, latched config=0; outputs cfg_ready=1, cnt_valid=0, cnt_last=0, busy=0, done=0.
- FSM states:
  - IDLE: cfg_ready=1. Config accepted -> ARMED. start ignored.
  - ARMED: cfg_ready=1; a new config overwrites the latched config.
    - start=1 -> RUN next edge, with cnt_data=0, phase=0.
    - If cfg handshake and start occur in the same cycle, the new config is latched and used for the run.
  - RUN: cfg_ready=0, busy=1, cnt_valid=1. cnt_data is presented from the first RUN cycle, giving 1 cycle latency from start to first beat.
  - DONE: one cycle, done=1, then -> IDLE. The config stays latched; a new config is required before the next start.
- Step rule, applied on each accepted beat (cnt_valid && cnt_ready):
  - P=0: step=1 always, no skipping.
  - P>=1, phase==P-1: step=2, phase<=0. Otherwise step=1, phase<=phase+1. P=1 therefore always steps by 2.
- Arithmetic:
  - next = cnt_data + step, computed in WIDTH+1 bits.
  - cnt_last = (cnt_data == limit) || (next > limit). This is combinational from cnt_data, phase and limit.
- Last beat accepted:
  - One-shot: -> DONE.
  - Continuous: cnt_data<=0, phase<=0, stay in RUN with no bubble.
- cfg_limit=0: the single beat is 0 with last=1.
- Backpressure: while cnt_valid && !cnt_ready, cnt_data, cnt_last and phase hold stable.
- stop in RUN:
  - -> IDLE next edge, no done pulse.
  - If a handshake occurs in the same cycle, that beat counts as transferred.
  - Config is retained but the FSM returns to IDLE; re-arming requires a new config.
- Async reset mid-run: all state returns to reset values immediately, with no done pulse and no partial beat.
- All state registers sit in a single async-reset always block. Outputs are registered except cnt_last and cfg_ready (decode of state).

Optional Feature:
- Macro: SKIP_SEQ_CTRL_WRAPCNT_EN.
- When defined:
  - Adds output port wrap_cnt [7:0] counting completed passes (accepted last beats) in continuous mode.
  - Saturates at 255, clears on config accept and on reset, and holds its value in IDLE/ARMED.
- When undefined: the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- P=3, limit=10, one-shot, cnt_ready=1 -> beats 0,1,2,4,5,6,8,9,10; last only on 10; done pulses 1 cycle after the beat-10 handshake; FSM returns to IDLE.
- P=0, limit=5 -> beats 0..5. P=1, limit=7 -> beats 0,2,4,6 with last on 6 (since 8>7). limit=0 -> single beat 0 with last=1.
- P=3, limit=10: hold cnt_ready=0 for 3 cycles while cnt_data=4 -> data stays 4 and last stays 0; on release the next beat is 5.
- Continuous, P=3, limit=4 -> 0,1,2,4(last),0,1,2,4(last),0 with no idle cycle; with macro, wrap_cnt=2 after the second last.
- Stop asserted on the cycle beat 5 is accepted (P=3, limit=10) -> FSM goes to IDLE, cnt_valid=0 next cycle, done never pulses, cfg_ready=1.
- Assert rst mid-run at cnt_data=6 -> outputs go to reset values immediately; a start without a new config is ignored.

Source files
------------

// File: rtl/skip_seq_ctrl.sv
// Skip-by-N count sequencer: config via valid/ready, armed then started, streams counts with last flag.
// Optional pass counter output wrap_cnt is enabled by defining SKIP_SEQ_CTRL_WRAPCNT_EN.
//
// state | meaning
// IDLE  | waiting for a configuration, start ignored
// ARMED | config latched, waiting for start (new config may overwrite)
// RUN   | streaming count beats
// DONE  | one-cycle done pulse after a one-shot pass
module skip_seq_ctrl #(
    parameter int WIDTH = 9,
    parameter int PER_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [PER_W-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [WIDTH-1:0] cnt_data,
    output logic             cnt_last,
    output logic             busy,
    output logic             done
`ifdef SKIP_SEQ_CTRL_WRAPCNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_cnt;
    logic [PER_W-1:0]   r_phase;
    logic [WIDTH-1:0]   r_limit;
    logic [PER_W-1:0]   r_period;
    logic               r_mode;
    logic               r_cnt_valid;
    logic               r_busy;
    logic               r_done;
    logic               w_cnt_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_cfg_fire;
    logic               w_beat_fire;
    logic               w_phase_wrap;
    logic [1:0]         w_step;
    logic [WIDTH:0]     w_next;
    logic               w_last_cond;
`ifdef SKIP_SEQ_CTRL_WRAPCNT_EN
    logic [7:0]         r_wrap_cnt;
`endif

    assign cfg_ready   = (r_state == S_IDLE) || (r_state == S_ARMED);
    assign w_cfg_fire  = cfg_valid && cfg_ready;
    assign w_beat_fire = r_cnt_valid && cnt_ready;

    // Skip happens on the beat where the phase reaches P-1; P=0 never skips.
    assign w_phase_wrap = (r_period != '0) && (r_phase == (r_period - PER_ONE));
    assign w_step       = w_phase_wrap ? 2'd2 : 2'd1;
    assign w_next       = {1'b0, r_cnt} + {{(WIDTH-1){1'b0}}, w_step};
    assign w_last_cond  = (r_cnt == r_limit) || (w_next > {1'b0, r_limit});

    assign cnt_last  = (r_state == S_RUN) && w_last_cond;
    assign cnt_valid = r_cnt_valid;
    assign cnt_data  = r_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef SKIP_SEQ_CTRL_WRAPCNT_EN
    assign wrap_cnt  = r_wrap_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_phase     <= '0;
            r_limit     <= '0;
            r_period    <= '0;
            r_mode      <= 1'b0;
            r_cnt_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SKIP_SEQ_CTRL_WRAPCNT_EN
            r_wrap_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt_valid <= w_cnt_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;

            if (w_cfg_fire) begin
                r_limit  <= cfg_limit;
                r_period <= cfg_period;
                r_mode   <= cfg_mode;
            end

            if ((r_state == S_ARMED) && start) begin
                r_cnt   <= '0;
                r_phase <= '0;
            end else if ((r_state == S_RUN) && w_beat_fire) begin
                if (w_last_cond) begin
                    // One-shot keeps the final value visible; continuous restarts with no bubble.
                    if (r_mode) begin
                        r_cnt   <= '0;
                        r_phase <= '0;
                    end
                end else begin
                    r_cnt <= w_next[WIDTH-1:0];
                    if (w_phase_wrap || (r_period == '0))
                        r_phase <= '0;
                    else
                        r_phase <= r_phase + PER_ONE;
                end
            end

`ifdef SKIP_SEQ_CTRL_WRAPCNT_EN
            if (w_cfg_fire)
                r_wrap_cnt <= '0;
            else if ((r_state == S_RUN) && w_beat_fire && w_last_cond && r_mode
                     && (r_wrap_cnt != 8'hFF))
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cfg_fire) w_state_nxt = S_ARMED;
            S_ARMED: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (stop)
                    w_state_nxt = S_IDLE;
                else if (w_beat_fire && w_last_cond && !r_mode)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        case (w_state_nxt)
            S_RUN: begin
                w_cnt_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule
